// File: rtl/heli_pkg.sv
// Shared types and screen geometry for the helicopter game controller.
package heli_pkg;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_PLAY  = 2'd1,
        GS_CRASH = 2'd2
    } game_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int HELI_W   = 27;
    localparam int HELI_H   = 15;
    localparam int Y_MAX    = SCREEN_H - HELI_H;   // 465: lowest legal anchor row

    // 9.4 fixed-point position with a sign bit, signed 8-bit velocity
    localparam int FRAC_W = 4;
    localparam int INT_W  = 9;
    localparam int POS_W  = 14;
    localparam int VEL_W  = 8;

endpackage

// File: rtl/heli_physics_step.sv
// One frame of semi-implicit integration: saturate the new velocity first,
// then advance the position by it and flag which screen bound was crossed.
module heli_physics_step
    import heli_pkg::*;
#(
    parameter int GRAVITY = 2,
    parameter int THRUST  = 5,
    parameter int VMAX    = 48
) (
    input  logic signed [POS_W-1:0] pos,
    input  logic signed [VEL_W-1:0] vel,
    input  logic                    thrust,
    output logic signed [POS_W-1:0] pos_next,
    output logic signed [VEL_W-1:0] vel_next,
    output logic                    hit_top,
    output logic                    hit_bottom
);
    localparam logic signed [VEL_W+1:0] G_W     = (VEL_W+2)'(GRAVITY);
    localparam logic signed [VEL_W+1:0] T_W     = (VEL_W+2)'(THRUST);
    localparam logic signed [VEL_W+1:0] VMAX_P  = (VEL_W+2)'(VMAX);
    localparam logic signed [VEL_W+1:0] VMAX_N  = -(VEL_W+2)'(VMAX);
    // largest position whose integer part is still Y_MAX
    localparam logic signed [POS_W:0]   P_BOT   = (POS_W+1)'(((Y_MAX + 1) << FRAC_W) - 1);

    logic signed [VEL_W+1:0] v_sum;
    logic signed [POS_W:0]   p_sum;

    // velocity update with symmetric saturation, then position update
    always_comb begin
        v_sum = {{2{vel[VEL_W-1]}}, vel} + G_W - (thrust ? T_W : '0);
        if (v_sum > VMAX_P)
            vel_next = VMAX_P[VEL_W-1:0];
        else if (v_sum < VMAX_N)
            vel_next = VMAX_N[VEL_W-1:0];
        else
            vel_next = v_sum[VEL_W-1:0];

        p_sum      = {pos[POS_W-1], pos} + {{(POS_W+1-VEL_W){vel_next[VEL_W-1]}}, vel_next};
        hit_top    = p_sum[POS_W];
        hit_bottom = !p_sum[POS_W] && (p_sum > P_BOT);
        pos_next   = p_sum[POS_W-1:0];
    end

endmodule

// File: rtl/heli_motion_ctrl.sv
// Frame-synchronous helicopter game controller: IDLE/PLAY/CRASH sequencing,
// per-frame physics, collision latching. Optional frame score counter is
// built only when HELI_SCORE_EN is defined.
module heli_motion_ctrl
    import heli_pkg::*;
#(
    parameter int START_X      = 100,
    parameter int START_Y      = 232,
    parameter int GRAVITY      = 2,
    parameter int THRUST       = 5,
    parameter int VMAX         = 48,
    parameter int CRASH_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        start,
    input  logic        thrust,
    input  logic        collide,
    output logic [9:0]  heli_x,
    output logic [8:0]  heli_y,
    output logic [1:0]  game_state,
    output logic        crash_pulse
`ifdef HELI_SCORE_EN
    ,
    output logic [15:0] score
`endif
);
    localparam logic [1:0] S_IDLE  = GS_IDLE;
    localparam logic [1:0] S_PLAY  = GS_PLAY;
    localparam logic [1:0] S_CRASH = GS_CRASH;

    localparam int CW = $clog2(CRASH_FRAMES + 1);
    localparam logic signed [POS_W-1:0] POS_RST = POS_W'(START_Y << FRAC_W);
    localparam logic signed [POS_W-1:0] POS_BOT = POS_W'(Y_MAX << FRAC_W);

    logic [1:0]              state;
    logic signed [POS_W-1:0] pos;
    logic signed [VEL_W-1:0] vel;
    logic                    hit;
    logic [CW-1:0]           cnt;

    logic signed [POS_W-1:0] pos_next;
    logic signed [VEL_W-1:0] vel_next;
    logic                    hit_top;
    logic                    hit_bottom;
    logic                    crash_now;
    logic                    pos_sign_unused;

    heli_physics_step #(
        .GRAVITY (GRAVITY),
        .THRUST  (THRUST),
        .VMAX    (VMAX)
    ) u_step (
        .pos        (pos),
        .vel        (vel),
        .thrust     (thrust),
        .pos_next   (pos_next),
        .vel_next   (vel_next),
        .hit_top    (hit_top),
        .hit_bottom (hit_bottom)
    );

    // a collide on the frame_start cycle itself still counts for this frame
    assign crash_now = hit | collide | hit_top | hit_bottom;

    // game FSM, position/velocity registers and hit latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pos         <= POS_RST;
            vel         <= '0;
            hit         <= 1'b0;
            cnt         <= '0;
            crash_pulse <= 1'b0;
        end else begin
            crash_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_PLAY;
                        hit   <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (collide)
                        hit <= 1'b1;
                    if (frame_start) begin
                        hit <= 1'b0;
                        if (crash_now) begin
                            state       <= S_CRASH;
                            crash_pulse <= 1'b1;
                            cnt         <= CW'(CRASH_FRAMES);
                            vel         <= '0;
                            // a pure collision keeps the last committed position
                            if (hit_top)
                                pos <= '0;
                            else if (hit_bottom)
                                pos <= POS_BOT;
                        end else begin
                            pos <= pos_next;
                            vel <= vel_next;
                        end
                    end
                end
                S_CRASH: begin
                    if (frame_start) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state <= S_IDLE;
                            pos   <= POS_RST;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HELI_SCORE_EN
    // frames survived, cleared on game start, saturating
    always_ff @(posedge clk) begin
        if (reset)
            score <= '0;
        else if (state == S_IDLE && start)
            score <= '0;
        else if (state == S_PLAY && frame_start && !crash_now && score != 16'hFFFF)
            score <= score + 16'd1;
    end
`endif

    assign heli_x          = 10'(START_X);
    assign heli_y          = pos[FRAC_W+INT_W-1:FRAC_W];
    assign game_state      = state;
    assign pos_sign_unused = pos[POS_W-1];

endmodule

// File: tb/tb_heli_motion_ctrl.sv
// Self-checking bench for heli_motion_ctrl: integer game model plus directed
// scenarios. Define HELI_SCORE_EN to also exercise the score port.
module tb_heli_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        start = 1'b0;
    logic        thrust = 1'b0;
    logic        collide = 1'b0;
    logic [9:0]  heli_x;
    logic [8:0]  heli_y;
    logic [1:0]  game_state;
    logic        crash_pulse;
`ifdef HELI_SCORE_EN
    logic [15:0] score;
`endif

    heli_motion_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .start       (start),
        .thrust      (thrust),
        .collide     (collide),
        .heli_x      (heli_x),
        .heli_y      (heli_y),
        .game_state  (game_state),
        .crash_pulse (crash_pulse)
`ifdef HELI_SCORE_EN
        ,
        .score       (score)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int pulse_cnt = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- game model (plain integer rules) ----------------
    int m_state = 0, m_pos = 3712, m_vel = 0, m_hit = 0, m_cnt = 0, m_score = 0, m_pulse = 0;

    always @(posedge clk) begin
        int v, p;
        m_pulse = 0;
        if (reset) begin
            m_state = 0; m_pos = 232 * 16; m_vel = 0; m_hit = 0; m_cnt = 0; m_score = 0;
        end else if (m_state == 0) begin
            if (start) begin m_state = 1; m_hit = 0; m_score = 0; end
        end else if (m_state == 1) begin
            if (collide) m_hit = 1;
            if (frame_start) begin
                v = m_vel + 2 - (thrust ? 5 : 0);
                if (v > 48) v = 48;
                if (v < -48) v = -48;
                p = m_pos + v;
                if (m_hit || p < 0 || p / 16 > 465) begin
                    m_state = 2; m_pulse = 1; m_cnt = 60; m_vel = 0;
                    if (p < 0) m_pos = 0;
                    else if (p / 16 > 465) m_pos = 465 * 16;
                end else begin
                    m_pos = p; m_vel = v;
                    if (m_score < 65535) m_score++;
                end
                m_hit = 0;
            end
        end else begin
            if (frame_start) begin
                m_cnt--;
                if (m_cnt == 0) begin m_state = 0; m_pos = 232 * 16; end
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (crash_pulse) pulse_cnt++;
        if (chk_en) begin
            check("heli_y", int'(heli_y), m_pos / 16);
            check("game_state", int'(game_state), m_state);
            check("crash_pulse", int'(crash_pulse), m_pulse);
            check("heli_x", int'(heli_x), 100);
`ifdef HELI_SCORE_EN
            check("score", int'(score), m_score);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic frame(input bit th);
        @(negedge clk); frame_start = 1'b1; thrust = th;
        @(negedge clk); frame_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        int guard;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // idle frames without start do nothing
        repeat (3) frame(1'b0);
        check("idle_state", int'(game_state), 0);
        check("idle_y", int'(heli_y), 232);

        // free fall from rest
        pulse_start();
        check("play_entry", int'(game_state), 1);
        frame(1'b0);
        check("model_vel_1", m_vel, 2);
        check("model_pos_1", m_pos, 3714);
        check("fall_y_1", int'(heli_y), 232);
        repeat (7) frame(1'b0);
        check("model_vel_8", m_vel, 16);
        check("fall_y_8", int'(heli_y), 236);

        // climb: velocity saturates, then the top edge crashes us
        pulse_cnt = 0;
        repeat (30) frame(1'b1);
        check("model_vel_sat", m_vel, -48);
        check("climb_state", int'(game_state), 1);
        guard = 0;
        while (game_state != 2'd2 && guard < 150) begin frame(1'b1); guard++; end
        check("top_crash_state", int'(game_state), 2);
        check("top_crash_y", int'(heli_y), 0);
        check("crash_pulse_count", pulse_cnt, 1);

        // collide/start during CRASH have no effect; exit after 60 frames
        repeat (10) frame(1'b0);
        @(negedge clk); collide = 1'b1; start = 1'b1;
        @(negedge clk); collide = 1'b0; start = 1'b0;
        repeat (49) frame(1'b0);
        check("crash_hold", int'(game_state), 2);
        frame(1'b0);
        check("crash_exit", int'(game_state), 0);
        check("crash_exit_y", int'(heli_y), 232);

        // mid-frame collision crashes at the next frame boundary
        pulse_start();
        repeat (3) frame(1'b0);
        @(negedge clk); collide = 1'b1;
        @(negedge clk); collide = 1'b0;
        check("collide_wait", int'(game_state), 1);
        frame(1'b0);
        check("collide_crash", int'(game_state), 2);
        check("collide_y", int'(heli_y), 232);
        repeat (60) frame(1'b0);
        check("collide_exit", int'(game_state), 0);

        // start together with frame_start: enter PLAY, no physics yet
        @(negedge clk); start = 1'b1; frame_start = 1'b1;
        @(negedge clk); start = 1'b0; frame_start = 1'b0;
        check("sim_start_state", int'(game_state), 1);
        check("sim_start_vel", m_vel, 0);
        frame(1'b0);
        check("sim_start_pos", m_pos, 3714);

        // hover for 100 frames total
        repeat (99) frame(m_vel > 0);
        check("hover_state", int'(game_state), 1);
`ifdef HELI_SCORE_EN
        check("score_100", int'(score), 100);
`endif

        // reset mid-game
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("rst_state", int'(game_state), 0);
        check("rst_y", int'(heli_y), 232);
`ifdef HELI_SCORE_EN
        check("rst_score", int'(score), 0);
`endif
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
